// File: rtl/voice_pkg.sv
// Shared definitions for the voice-module command frame parser:
// FSM states, abort cause codes and the default framing bytes.
package voice_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_CMD   = 3'd1,
    S_PARAM = 3'd2,
    S_CHK   = 3'd3,
    S_TAIL  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_TAIL    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HEADER = 8'hAA;
  localparam logic [7:0] DEF_TAIL   = 8'h55;

endpackage

// File: rtl/voice_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the
// cycle on which the gap reaches the terminal count without a new byte.
module voice_byte_timeout #(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is only ever updated with non-blocking assignments
  // so every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A byte arriving on the terminal cycle clears the counter and wins.
  assign expired = en && !clr && (cnt == TERM);

endmodule

// File: rtl/voice_cmd_parser.sv
// Extracts HEADER/CMD/PARAM/CHK/TAIL frames from the UART byte stream and
// reports good commands (cmd_valid) or aborted frames (frame_err + err_code).
module voice_cmd_parser
  import voice_pkg::*;
#(
  parameter logic [7:0] HEADER  = DEF_HEADER,
  parameter logic [7:0] TAIL    = DEF_TAIL,
  parameter int         TIMEOUT = 100000,
  parameter int         CNT_W   = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_down,
  output logic [7:0] cmd,
  output logic [7:0] param,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t     state;
  logic [7:0] cmd_buf;
  logic [7:0] param_buf;
  logic [7:0] chk_exp;
  logic       in_frame;
  logic       tmo_clr;
  logic       expired;

  assign in_frame = (state != IDLE);
  assign busy     = in_frame;
  assign tmo_clr  = rx_down || !in_frame;
  assign chk_exp  = cmd_buf + param_buf;

  voice_byte_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (in_frame),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_buf   <= '0;
      param_buf <= '0;
      cmd       <= '0;
      param     <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // NOTE: pulse outputs default low every cycle; the branches below only
      // raise them, which keeps each pulse exactly one cycle wide.
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (expired) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= IDLE;
      end else if (rx_down) begin
        case (state)
          IDLE: begin
            if (rx_byte == HEADER) state <= S_CMD;
          end
          S_CMD: begin
            cmd_buf <= rx_byte;
            state   <= S_PARAM;
          end
          S_PARAM: begin
            param_buf <= rx_byte;
            state     <= S_CHK;
          end
          S_CHK: begin
            if (rx_byte == chk_exp) begin
              state <= S_TAIL;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= IDLE;
            end
          end
          S_TAIL: begin
            if (rx_byte == TAIL) begin
              cmd       <= cmd_buf;
              param     <= param_buf;
              cmd_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_TAIL;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_cmd_parser.sv
// Cycle-by-cycle comparison of the parser against a frame-level model that
// tracks bytes consumed and strobe timestamps.
module tb_voice_cmd_parser;

  localparam int TO = 40;
  localparam int CW = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_down = 1'b0;
  logic [7:0] cmd;
  logic [7:0] param;
  logic       cmd_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  voice_cmd_parser #(
    .HEADER  (8'hAA),
    .TAIL    (8'h55),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_down   (rx_down),
    .cmd       (cmd),
    .param     (param),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: number of frame bytes accepted so far and when the last
  // in-frame byte arrived; a frame dies TO cycles after its last byte.
  int         pos = 0;
  int         last_t = 0;
  logic [7:0] m_cbuf = 8'h00;
  logic [7:0] m_pbuf = 8'h00;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_param = 8'h00;
  logic [1:0] m_code = 2'd0;
  logic       exp_err = 1'b0;
  logic       exp_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input logic d, input logic [7:0] b);
    logic [7:0] sum;
    exp_err   = 1'b0;
    exp_valid = 1'b0;
    sum = m_cbuf + m_pbuf;
    if (d) begin
      last_t = cyc;
      case (pos)
        0: if (b == 8'hAA) pos = 1;
        1: begin m_cbuf = b; pos = 2; end
        2: begin m_pbuf = b; pos = 3; end
        3: begin
          if (b == sum) pos = 4;
          else begin exp_err = 1'b1; m_code = 2'd1; pos = 0; end
        end
        default: begin
          if (b == 8'h55) begin
            exp_valid = 1'b1; m_cmd = m_cbuf; m_param = m_pbuf;
          end else begin
            exp_err = 1'b1; m_code = 2'd2;
          end
          pos = 0;
        end
      endcase
    end else if (pos != 0 && cyc - last_t >= TO) begin
      exp_err = 1'b1;
      m_code  = 2'd3;
      pos     = 0;
    end
  endtask

  task automatic compare_all();
    check("frame_err", frame_err, exp_err);
    check("cmd_valid", cmd_valid, exp_valid);
    check("busy", busy, pos != 0);
    check("err_code", err_code, m_code);
    check("cmd", cmd, m_cmd);
    check("param", param, m_param);
  endtask

  task automatic tick(input logic d, input logic [7:0] b);
    rx_down = d;
    rx_byte = b;
    @(posedge clk);
    cyc++;
    #1;
    model_step(d, b);
    compare_all();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap - 1) tick(1'b0, 8'h00);
    tick(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] p,
                            input logic [7:0] k, input logic [7:0] t, input int gap);
    send(8'hAA, gap);
    send(c, gap);
    send(p, gap);
    send(k, gap);
    send(t, gap);
  endtask

  function automatic int rand_gap();
    int sel;
    sel = int'($urandom_range(0, 19));
    if (sel == 0) return TO + 1 + int'($urandom_range(0, 4));
    if (sel < 3) return TO;
    return int'($urandom_range(2, 12));
  endfunction

  initial begin
    logic [7:0] c, p, k, t;
    int kind;

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 8'h00);

    // Good frame, then checksum error with a stray tail, then tail error.
    send_frame(8'h01, 8'h02, 8'h03, 8'h55, TO / 4);
    repeat (4) tick(1'b0, 8'h00);
    send_frame(8'h10, 8'h20, 8'h31, 8'h55, 5);
    send_frame(8'h10, 8'h20, 8'h30, 8'h54, 3);

    // Timeout after a partial frame, then recovery.
    send(8'hAA, 4);
    send(8'h05, 4);
    repeat (TO + 3) tick(1'b0, 8'h00);
    send_frame(8'h05, 8'h06, 8'h0B, 8'h55, 6);

    // Garbage in idle, HEADER as command data, strobes on the terminal count.
    send(8'h00, 3);
    send(8'hFF, 3);
    send(8'h55, 3);
    send_frame(8'hAA, 8'h01, 8'hAB, 8'h55, TO);

    // Reset in the middle of a frame.
    send(8'hAA, 3);
    send(8'h01, 3);
    rx_down = 1'b0;
    rst_n   = 1'b0;
    #1;
    pos = 0; m_cmd = 8'h00; m_param = 8'h00; m_code = 2'd0;
    exp_err = 1'b0; exp_valid = 1'b0;
    compare_all();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();
    send_frame(8'h3C, 8'hC4, 8'h00, 8'h55, 5);

    // Randomized frames: good, bad checksum, bad tail, idle garbage.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 5));
      c = 8'($urandom);
      p = 8'($urandom);
      k = c + p;
      t = 8'h55;
      if (kind == 3) k = k ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 4) t = 8'($urandom_range(0, 255)) | 8'h80;
      if (kind == 5) begin
        send(8'($urandom) & 8'h7F, rand_gap());
      end else begin
        send(8'hAA, rand_gap());
        send(c, rand_gap());
        send(p, rand_gap());
        send(k, rand_gap());
        send(t, rand_gap());
      end
    end
    repeat (TO + 4) tick(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
